// File: rtl/pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller.
package pipe_pkg;

    localparam int unsigned PIPE_REG_AW = 5;
    localparam int unsigned CTRL_W      = 17;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FREEZE     = 2'd2
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

endpackage

// File: rtl/pipeline_hazard_controller_fwd_select.sv
// Per-operand forwarding priority mux: EX (non-load) > MEM > WB > register file.
module fwd_select
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW = PIPE_REG_AW
) (
    input  logic [REG_AW-1:0] i_rs,
    input  logic              i_use,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic              i_ex_regwrite,
    input  logic              i_ex_load,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_mem_regwrite,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic              i_wb_regwrite,
    output logic [1:0]        o_sel,
    output logic              o_ex_hit
);

    logic w_mem_hit;
    logic w_wb_hit;

    // r0 is hardwired, so a zero destination never forwards
    assign o_ex_hit  = i_use && i_ex_regwrite  && (i_ex_rd  != '0) && (i_ex_rd  == i_rs);
    assign w_mem_hit = i_use && i_mem_regwrite && (i_mem_rd != '0) && (i_mem_rd == i_rs);
    assign w_wb_hit  = i_use && i_wb_regwrite  && (i_wb_rd  != '0) && (i_wb_rd  == i_rs);

    always_comb begin
        o_sel = FWD_RF;
        if (o_ex_hit && !i_ex_load) begin
            o_sel = FWD_EX;
        end else if (w_mem_hit) begin
            o_sel = FWD_MEM;
        end else if (w_wb_hit) begin
            o_sel = FWD_WB;
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencer: load-use stall, delay-slot annul, memory freeze/timeout, forwarding.
// Optional performance counters are built when PHC_PERF_CNT_EN is defined.
module pipeline_hazard_controller
    import pipe_pkg::*;
#(
    parameter int unsigned REG_AW   = PIPE_REG_AW,
    parameter int unsigned MAX_WAIT = 15,
    parameter int unsigned WAIT_W   = $clog2(MAX_WAIT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              ex_regwrite,
    input  logic              mem_regwrite,
    input  logic              wb_regwrite,
    input  logic              ex_load,
    input  logic              annul_req,
    input  logic              mem_busy,
    output logic              pc_le,
    output logic              ifid_le,
    output logic              ifid_flush,
    output logic              idex_nop,
    output logic              pipe_freeze,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              mem_timeout,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       freeze_cnt,
    output logic [31:0]       annul_cnt
);

    localparam logic [WAIT_W-1:0] L_WAIT_MAX = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0] L_WAIT_ONE = WAIT_W'(1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_pend;
    logic              w_pend_nxt;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_nxt;
    logic              r_timeout;
    logic              w_timeout_set;
    logic [1:0]        w_fwd_a;
    logic [1:0]        w_fwd_b;
    logic              w_ex_hit_a;
    logic              w_ex_hit_b;
    logic              w_load_use;

    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .i_rs           (id_rs1),
        .i_use          (id_use_rs1),
        .i_ex_rd        (ex_rd),
        .i_ex_regwrite  (ex_regwrite),
        .i_ex_load      (ex_load),
        .i_mem_rd       (mem_rd),
        .i_mem_regwrite (mem_regwrite),
        .i_wb_rd        (wb_rd),
        .i_wb_regwrite  (wb_regwrite),
        .o_sel          (w_fwd_a),
        .o_ex_hit       (w_ex_hit_a)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .i_rs           (id_rs2),
        .i_use          (id_use_rs2),
        .i_ex_rd        (ex_rd),
        .i_ex_regwrite  (ex_regwrite),
        .i_ex_load      (ex_load),
        .i_mem_rd       (mem_rd),
        .i_mem_regwrite (mem_regwrite),
        .i_wb_rd        (wb_rd),
        .i_wb_regwrite  (wb_regwrite),
        .o_sel          (w_fwd_b),
        .o_ex_hit       (w_ex_hit_b)
    );

    // The load already moved to MEM during LOAD_STALL, so no second stall there
    assign w_load_use = ex_load && ex_regwrite && (ex_rd != '0)
                        && (w_ex_hit_a || w_ex_hit_b) && (r_state != LOAD_STALL);

    always_comb begin
        pc_le         = 1'b1;
        ifid_le       = 1'b1;
        ifid_flush    = 1'b0;
        idex_nop      = 1'b0;
        pipe_freeze   = 1'b0;
        w_state_nxt   = RUN;
        w_pend_nxt    = r_pend;
        w_wait_nxt    = '0;
        w_timeout_set = 1'b0;
        if (reset) begin
            w_pend_nxt = 1'b0;
        end else if (mem_busy) begin
            pc_le       = 1'b0;
            ifid_le     = 1'b0;
            pipe_freeze = 1'b1;
            w_pend_nxt  = r_pend || annul_req;
            w_state_nxt = FREEZE;
            if (r_state == FREEZE) begin
                w_timeout_set = (r_wait >= L_WAIT_MAX);
                w_wait_nxt    = (r_wait >= L_WAIT_MAX) ? L_WAIT_MAX : r_wait + L_WAIT_ONE;
            end else begin
                w_wait_nxt = L_WAIT_ONE;
            end
        end else if (w_load_use) begin
            pc_le       = 1'b0;
            ifid_le     = 1'b0;
            idex_nop    = 1'b1;
            w_state_nxt = LOAD_STALL;
        end else if (annul_req || r_pend) begin
            ifid_flush = 1'b1;
            w_pend_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RUN;
            r_pend    <= 1'b0;
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend    <= w_pend_nxt;
            r_wait    <= w_wait_nxt;
            r_timeout <= r_timeout || w_timeout_set;
        end
    end

    assign fwd_a       = reset ? FWD_RF : w_fwd_a;
    assign fwd_b       = reset ? FWD_RF : w_fwd_b;
    assign mem_timeout = r_timeout && !reset;

`ifdef PHC_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_freeze_cnt;
    logic [31:0] r_annul_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_freeze_cnt <= '0;
            r_annul_cnt  <= '0;
        end else begin
            if (idex_nop)    r_stall_cnt  <= r_stall_cnt + 32'd1;
            if (pipe_freeze) r_freeze_cnt <= r_freeze_cnt + 32'd1;
            if (ifid_flush)  r_annul_cnt  <= r_annul_cnt + 32'd1;
        end
    end

    assign stall_cnt  = reset ? '0 : r_stall_cnt;
    assign freeze_cnt = reset ? '0 : r_freeze_cnt;
    assign annul_cnt  = reset ? '0 : r_annul_cnt;
`else
    assign stall_cnt  = '0;
    assign freeze_cnt = '0;
    assign annul_cnt  = '0;
`endif

endmodule
